issue_queue_entry_allocator: RTL and testbench
==============================================

Name: issue_queue_entry_allocator

Overview:
- Enqueue-side controller for the age-ordered issue queue: owns the per-entry valid vector and picks free slots for up to EnqWidth incoming instructions per cycle.
- Frees entries when the selector side dequeues them.
- Outputs drive the age-matrix selector's enq_fire/enq_mask/entry_vld inputs directly; it is the writer for the selector's reader.

Parameters:
EntryCount, 8, number of queue entries (>=2)
EnqWidth, 2, allocation lanes per cycle (1..EntryCount)
CntWidth, $clog2(EntryCount+1), width of occupancy counters (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
enq_vld_i  input  EnqWidth  per-lane allocation request
enq_rdy_o  output  EnqWidth  per-lane ready; depends on registered state only
enq_fire_o  output  EnqWidth  enq_vld_i & enq_rdy_o, gated by flush
enq_mask_o  output  EnqWidth x EntryCount  one-hot slot granted to each firing lane, zero otherwise
deq_fire_i  input  1  dequeue strobe from issue/select side
deq_mask_i  input  EntryCount  entries released when deq_fire_i (multi-hot allowed)
flush_i  input  1  invalidate all entries
entry_vld_o  output  EntryCount  registered valid vector
free_cnt_o  output  CntWidth  registered count of free entries
full_o  output  1  free_cnt_o == 0
empty_o  output  1  free_cnt_o == EntryCount
err_o  output  1  sticky: dequeue of an invalid entry was seen

Behaviour:
- Reset (sync, rst high at posedge):
  - vld_q = 0, free_cnt_q = EntryCount, err_q = 0.
  - Hence full_o=0, empty_o=1, enq_rdy_o=0 during the reset cycle, enq_fire_o=0.
- Ready: enq_rdy_o[i] = !rst & !flush_i & (free_cnt_q > i). Lane ready never depends on enq_vld_i.
- Fire: enq_fire_o[i] = enq_vld_i[i] & enq_rdy_o[i]. Lanes may fire non-contiguously, e.g. lane 0 idle and lane 1 firing.
- Slot choice:
  - k = number of firing lanes with index < i.
  - enq_mask_o[i] = one-hot of the (k)-th lowest-index entry with vld_q == 0 (0-based).
  - Firing lanes always receive distinct slots. Lower lanes get lower-index slots.
- No same-cycle reuse: entries released by deq this cycle are not allocatable until the next cycle. Free set = ~vld_q only.
- Next state, normal:
  - deq_eff = deq_fire_i ? deq_mask_i : 0.
  - vld_d = (vld_q & ~deq_eff) | OR_i(enq_mask_o[i]).
  - free_cnt_d = free_cnt_q + popcount(deq_eff & vld_q) - popcount(enq_fire_o).
  - Maintained as a counter, not recomputed by popcount of vld.
- Invariant: free_cnt_q == EntryCount - popcount(vld_q) at every cycle.
- Simultaneous enq and deq in the same cycle: both apply. They never collide, because enq targets only entries that were invalid at cycle start.
- Deq of an invalid entry (deq_fire_i & deq_mask_i[j] & !vld_q[j]):
  - The bit is ignored for counting.
  - err_q set to 1; cleared only by rst.
- Flush (flush_i=1):
  - enq_rdy_o/enq_fire_o forced 0.
  - vld_d = 0, free_cnt_d = EntryCount. Deq in the same cycle is ignored, and err is not set by it.
  - Outputs show empty the next cycle.
- Reset mid-traffic: all pending state discarded; same as power-up reset; rst overrides flush.
- Latency: allocation visible on enq_mask_o combinationally in the request cycle. entry_vld_o/free_cnt_o/full_o/empty_o update one cycle later.
- full_o/empty_o are decoded from free_cnt_q (registered).

Test Plan (EntryCount=4, EnqWidth=2):
- Reset then enq_vld_i=2'b11:
  - enq_rdy_o=2'b11, enq_mask_o[0]=4'b0001, enq_mask_o[1]=4'b0010.
  - Next cycle entry_vld_o=4'b0011, free_cnt_o=2.
- vld=4'b0101, enq_vld_i=2'b10 (lane 1 only) -> enq_mask_o[1]=4'b0010, enq_mask_o[0]=0; next entry_vld_o=4'b0111, free_cnt_o=1.
- vld=4'b0111, enq_vld_i=2'b11:
  - enq_rdy_o=2'b01; only lane 0 fires with mask 4'b1000.
  - Next full_o=1, free_cnt_o=0, enq_rdy_o=0.
- Full, deq_fire_i=1, deq_mask_i=4'b0100, enq_vld_i=2'b01 in the same cycle:
  - No enq fire (rdy=0, no same-cycle reuse).
  - Next entry_vld_o=4'b1011, free_cnt_o=1; following cycle lane 0 gets 4'b0100.
- vld=4'b0011, deq_fire_i=1, deq_mask_i=4'b1001 -> next entry_vld_o=4'b0010, free_cnt_o=3, err_o=1 and it stays 1 until rst.
- vld=4'b1111, flush_i=1 with enq_vld_i=2'b11 and deq_fire_i=1 -> enq_fire_o=0; next entry_vld_o=0, free_cnt_o=4, empty_o=1, err_o unchanged.

Source files
------------

// File: rtl/issue_queue_entry_allocator.sv
// Enqueue-side allocator for an age-ordered issue queue.
//
// Owns the per-entry valid vector and hands out free slots to up to EnqWidth
// requesting lanes per cycle. Entries are released by the selector side via
// deq_fire_i/deq_mask_i. Outputs feed the age-matrix selector directly.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   enq_vld_i    per-lane allocation request
//   enq_rdy_o    per-lane ready, from registered state only
//   enq_fire_o   enq_vld_i & enq_rdy_o
//   enq_mask_o   one-hot slot granted to each firing lane, zero otherwise
//   deq_fire_i   dequeue strobe
//   deq_mask_i   entries released when deq_fire_i (multi-hot)
//   flush_i      invalidate all entries
//   entry_vld_o  registered valid vector
//   free_cnt_o   registered free-entry count
//   full_o       no free entries
//   empty_o      all entries free
//   err_o        sticky: dequeue of an invalid entry was seen

module issue_queue_entry_allocator #(
    parameter int unsigned EntryCount = 8,
    parameter int unsigned EnqWidth   = 2,
    localparam int unsigned CntWidth  = $clog2(EntryCount + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [EnqWidth-1:0]                 enq_vld_i,
    output logic [EnqWidth-1:0]                 enq_rdy_o,
    output logic [EnqWidth-1:0]                 enq_fire_o,
    output logic [EnqWidth-1:0][EntryCount-1:0] enq_mask_o,
    input  logic                                deq_fire_i,
    input  logic [EntryCount-1:0]               deq_mask_i,
    input  logic                                flush_i,
    output logic [EntryCount-1:0]               entry_vld_o,
    output logic [CntWidth-1:0]                 free_cnt_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic                                err_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(EntryCount);

    logic [EntryCount-1:0] vld_q, vld_d;
    logic [CntWidth-1:0]   free_cnt_q, free_cnt_d;
    logic                  err_q, err_d;

    logic [EntryCount-1:0] avail;
    logic [EntryCount-1:0] alloc_vec;
    logic [EntryCount-1:0] deq_eff;
    logic [EntryCount-1:0] deq_hit;
    logic [EntryCount-1:0] deq_bad;
    logic [CntWidth-1:0]   rel_cnt;
    logic [CntWidth-1:0]   enq_cnt;
    logic                  found;

    // Lane i is ready when at least i+1 entries are free, so every ready lane
    // is guaranteed a slot even if all lower lanes fire.
    always_comb begin
        enq_rdy_o = '0;
        for (int i = 0; i < int'(EnqWidth); i++) begin
            enq_rdy_o[i] = !rst && !flush_i && (free_cnt_q > CntWidth'(i));
        end
    end

    assign enq_fire_o = enq_vld_i & enq_rdy_o;

    // Walk lanes in order, each firing lane taking the lowest remaining free
    // entry. This gives lane i the k-th lowest free slot, where k counts the
    // firing lanes below it. Only entries invalid at cycle start are free.
    always_comb begin
        enq_mask_o = '0;
        alloc_vec  = '0;
        avail      = ~vld_q;
        for (int i = 0; i < int'(EnqWidth); i++) begin
            found = 1'b0;
            if (enq_fire_o[i]) begin
                for (int j = 0; j < int'(EntryCount); j++) begin
                    if (!found && avail[j]) begin
                        enq_mask_o[i][j] = 1'b1;
                        avail[j]         = 1'b0;
                        found            = 1'b1;
                    end
                end
            end
            alloc_vec = alloc_vec | enq_mask_o[i];
        end
    end

    assign deq_eff = deq_fire_i ? deq_mask_i : '0;
    assign deq_hit = deq_eff & vld_q;
    assign deq_bad = deq_eff & ~vld_q;

    always_comb begin
        rel_cnt = '0;
        for (int j = 0; j < int'(EntryCount); j++) begin
            rel_cnt = rel_cnt + CntWidth'(deq_hit[j]);
        end
    end

    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < int'(EnqWidth); i++) begin
            enq_cnt = enq_cnt + CntWidth'(enq_fire_o[i]);
        end
    end

    always_comb begin
        vld_d      = (vld_q & ~deq_eff) | alloc_vec;
        free_cnt_d = free_cnt_q + rel_cnt - enq_cnt;
        err_d      = err_q | (|deq_bad);
        if (flush_i) begin
            // Flush discards same-cycle dequeues, including their error check.
            vld_d      = '0;
            free_cnt_d = CntMax;
            err_d      = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            free_cnt_q <= CntMax;
            err_q      <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign entry_vld_o = vld_q;
    assign free_cnt_o  = free_cnt_q;
    assign full_o      = (free_cnt_q == '0);
    assign empty_o     = (free_cnt_q == CntMax);
    assign err_o       = err_q;

endmodule

// File: tb/tb_issue_queue_entry_allocator.sv
// Directed bench for issue_queue_entry_allocator (EntryCount=4, EnqWidth=2).
// Stimulus drives each cycle's inputs and pushes the hand-computed expected
// outputs for that cycle; a monitor pops and compares on the falling edge.

module tb_issue_queue_entry_allocator;

    localparam int unsigned EntryCount = 4;
    localparam int unsigned EnqWidth   = 2;
    localparam int unsigned CntWidth   = $clog2(EntryCount + 1);

    logic                                clk;
    logic                                rst;
    logic [EnqWidth-1:0]                 enq_vld;
    logic [EnqWidth-1:0]                 enq_rdy;
    logic [EnqWidth-1:0]                 enq_fire;
    logic [EnqWidth-1:0][EntryCount-1:0] enq_mask;
    logic                                deq_fire;
    logic [EntryCount-1:0]               deq_mask;
    logic                                flush;
    logic [EntryCount-1:0]               entry_vld;
    logic [CntWidth-1:0]                 free_cnt;
    logic                                full;
    logic                                empty;
    logic                                err;

    issue_queue_entry_allocator #(
        .EntryCount(EntryCount),
        .EnqWidth  (EnqWidth)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enq_vld_i  (enq_vld),
        .enq_rdy_o  (enq_rdy),
        .enq_fire_o (enq_fire),
        .enq_mask_o (enq_mask),
        .deq_fire_i (deq_fire),
        .deq_mask_i (deq_mask),
        .flush_i    (flush),
        .entry_vld_o(entry_vld),
        .free_cnt_o (free_cnt),
        .full_o     (full),
        .empty_o    (empty),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] rdy;
        logic [1:0] fire;
        logic [3:0] m0;
        logic [3:0] m1;
        logic [3:0] vld;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    task automatic chk(input string name, input int id, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL vec%0d %s: got %b expected %b", id, name, act, req);
        end
    endtask

    // Monitor: compares every cycle that has a pending expectation.
    always @(negedge clk) begin
        exp_t e;
        int   id;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = vec_id;
            vec_id++;
            chk("enq_rdy",   id, 8'(enq_rdy),     8'(e.rdy));
            chk("enq_fire",  id, 8'(enq_fire),    8'(e.fire));
            chk("enq_mask0", id, 8'(enq_mask[0]), 8'(e.m0));
            chk("enq_mask1", id, 8'(enq_mask[1]), 8'(e.m1));
            chk("entry_vld", id, 8'(entry_vld),   8'(e.vld));
            chk("free_cnt",  id, 8'(free_cnt),    8'(e.cnt));
            chk("full",      id, 8'(full),        8'(e.full));
            chk("empty",     id, 8'(empty),       8'(e.empty));
            chk("err",       id, 8'(err),         8'(e.err));
        end
    end

    // Drive one cycle of inputs and queue what the DUT must show this cycle.
    task automatic step(input logic r, input logic [1:0] ev, input logic df,
                        input logic [3:0] dm, input logic fl,
                        input logic [1:0] x_rdy, input logic [1:0] x_fire,
                        input logic [3:0] x_m0, input logic [3:0] x_m1,
                        input logic [3:0] x_vld, input logic [2:0] x_cnt,
                        input logic x_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        enq_vld  = ev;
        deq_fire = df;
        deq_mask = dm;
        flush    = fl;
        e.rdy   = x_rdy;
        e.fire  = x_fire;
        e.m0    = x_m0;
        e.m1    = x_m1;
        e.vld   = x_vld;
        e.cnt   = x_cnt;
        e.full  = (x_cnt == 3'd0);
        e.empty = (x_cnt == 3'd4);
        e.err   = x_err;
        exp_q.push_back(e);
    endtask

    initial begin
        rst      = 1'b1;
        enq_vld  = '0;
        deq_fire = 1'b0;
        deq_mask = '0;
        flush    = 1'b0;
        @(posedge clk);
        //    rst  enq   df  dmask   fl  rdy    fire   m0       m1       vld      cnt  err
        // Reset cycle: requests are ignored.
        step(1, 2'b11, 0, 4'b0000, 0, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
        // Two lanes from empty.
        step(0, 2'b11, 0, 4'b0000, 0, 2'b11, 2'b11, 4'b0001, 4'b0010, 4'b0000, 3'd4, 0);
        step(0, 2'b00, 1, 4'b0010, 0, 2'b11, 2'b00, 4'b0000, 4'b0000, 4'b0011, 3'd2, 0);
        // Hole at entry 1 gets reused lowest-first.
        step(0, 2'b11, 0, 4'b0000, 0, 2'b11, 2'b11, 4'b0010, 4'b0100, 4'b0001, 3'd3, 0);
        step(0, 2'b00, 1, 4'b0010, 0, 2'b01, 2'b00, 4'b0000, 4'b0000, 4'b0111, 3'd1, 0);
        // Lane 1 alone takes the lowest free slot.
        step(0, 2'b10, 0, 4'b0000, 0, 2'b11, 2'b10, 4'b0000, 4'b0010, 4'b0101, 3'd2, 0);
        // One free entry: only lane 0 ready.
        step(0, 2'b11, 0, 4'b0000, 0, 2'b01, 2'b01, 4'b1000, 4'b0000, 4'b0111, 3'd1, 0);
        // Full: deq this cycle does not make room this cycle.
        step(0, 2'b01, 1, 4'b0100, 0, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b1111, 3'd0, 0);
        step(0, 2'b01, 0, 4'b0000, 0, 2'b01, 2'b01, 4'b0100, 4'b0000, 4'b1011, 3'd1, 0);
        step(0, 2'b00, 1, 4'b1100, 0, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b1111, 3'd0, 0);
        // Deq of invalid entry 3 sets sticky err and is not counted.
        step(0, 2'b00, 1, 4'b1001, 0, 2'b11, 2'b00, 4'b0000, 4'b0000, 4'b0011, 3'd2, 0);
        step(0, 2'b11, 0, 4'b0000, 0, 2'b11, 2'b11, 4'b0001, 4'b0100, 4'b0010, 3'd3, 1);
        step(0, 2'b01, 0, 4'b0000, 0, 2'b01, 2'b01, 4'b1000, 4'b0000, 4'b0111, 3'd1, 1);
        // Flush with enq and deq pending.
        step(0, 2'b11, 1, 4'b0001, 1, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b1111, 3'd0, 1);
        step(0, 2'b00, 0, 4'b0000, 0, 2'b11, 2'b00, 4'b0000, 4'b0000, 4'b0000, 3'd4, 1);
        // Reset mid-run clears err; rst also overrides flush.
        step(1, 2'b11, 0, 4'b0000, 1, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 3'd4, 1);
        // Mask without strobe is ignored.
        step(0, 2'b00, 0, 4'b1111, 0, 2'b11, 2'b00, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
        // Flush on empty with invalid deq does not set err.
        step(0, 2'b00, 1, 4'b1111, 1, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);
        step(0, 2'b00, 0, 4'b0000, 0, 2'b11, 2'b00, 4'b0000, 4'b0000, 4'b0000, 3'd4, 0);

        for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
